// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the FP multiplier exception stage.
// Contents:
//   rnd_t          rounding-mode encoding; codes 101-111 act as RNE
//   interp_t       how the final result word is interpreted
//   STK_*          bit positions inside the sticky flag vector
//   *_mag()        special-value magnitudes (sign bit excluded), sized by
//                  EXP_W / MAN_W and returned in a 64-bit container
package fp_mul_pkg;

  typedef enum logic [2:0] {
    RPINF = 3'b000,
    RNINF = 3'b001,
    RZ    = 3'b010,
    RNA   = 3'b011,
    RNE   = 3'b100
  } rnd_t;

  typedef enum logic [2:0] {
    ZERO,
    INF,
    NAN,
    NORM,
    MIN_NORM,
    MAX_NORM
  } interp_t;

  localparam int STK_NAN     = 0;
  localparam int STK_INEXACT = 1;
  localparam int STK_TINY    = 2;
  localparam int STK_HUGE    = 3;
  localparam int STK_INVALID = 4;
  localparam int STK_W       = 5;

  // Exponent field all ones, fraction zero.
  function automatic logic [63:0] inf_mag(input int exp_w, input int man_w);
    return ((64'd1 << exp_w) - 64'd1) << man_w;
  endfunction

  // Canonical NaN: exponent all ones, fraction 0..01.
  function automatic logic [63:0] nan_mag(input int exp_w, input int man_w);
    return inf_mag(exp_w, man_w) | 64'd1;
  endfunction

  // Largest finite: exponent all ones minus one, fraction all ones.
  function automatic logic [63:0] max_norm_mag(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd2) << man_w) | ((64'd1 << man_w) - 64'd1);
  endfunction

  // Smallest normal: exponent 0..01, fraction zero.
  function automatic logic [63:0] min_norm_mag(input int exp_w, input int man_w);
    return 64'd1 << man_w;
  endfunction

  // Fraction MSB, the quiet bit of a NaN.
  function automatic logic [63:0] quiet_mask(input int exp_w, input int man_w);
    return (64'd1 << (man_w - 1)) & ~(64'd0 << exp_w);
  endfunction

endpackage

// File: rtl/fp_mul_exc_resolve.sv
// Combinational operand classification and exception priority resolution
// for the FP multiplier.
// Ports:
//   a, b        original operands (W bits)
//   z_calc      datapath-rounded product
//   round       rounding mode (rnd_t encoding)
//   ovf, unf, inexact   datapath status
//   z           resolved result
//   zero_f .. invalid_f per-result flags
// Build option: FP_MUL_EXC_NAN_PROP_EN makes a NaN operand propagate its
// own quieted payload (a before b) instead of the canonical NaN.
module fp_mul_exc_resolve
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] z_calc,
  input  logic [2:0]   round,
  input  logic         ovf,
  input  logic         unf,
  input  logic         inexact,
  output logic [W-1:0] z,
  output logic         zero_f,
  output logic         inf_f,
  output logic         nan_f,
  output logic         tiny_f,
  output logic         huge_f,
  output logic         inexact_f,
  output logic         invalid_f
);

  localparam logic [63:0] INF_L  = inf_mag(EXP_W, MAN_W);
  localparam logic [63:0] NAN_L  = nan_mag(EXP_W, MAN_W);
  localparam logic [63:0] MAXN_L = max_norm_mag(EXP_W, MAN_W);
  localparam logic [63:0] MINN_L = min_norm_mag(EXP_W, MAN_W);
  localparam logic [W-2:0] INF_M  = INF_L[W-2:0];
  localparam logic [W-2:0] MAXN_M = MAXN_L[W-2:0];
  localparam logic [W-2:0] MINN_M = MINN_L[W-2:0];
  localparam logic [W-1:0] NAN_C  = NAN_L[W-1:0];
`ifdef FP_MUL_EXC_NAN_PROP_EN
  localparam logic [63:0]  QM_L   = quiet_mask(EXP_W, MAN_W);
  localparam logic [W-1:0] QMASK  = QM_L[W-1:0];
`endif

  function automatic interp_t classify(input logic [W-1:0] x);
    logic exp_ones, exp_zero, man_zero;
    exp_ones = &x[W-2:MAN_W];
    exp_zero = ~|x[W-2:MAN_W];
    man_zero = ~|x[MAN_W-1:0];
    if (exp_zero && man_zero) return ZERO;
    if (exp_ones && man_zero) return INF;
    if (exp_ones)             return NAN;
    return NORM;
  endfunction

  // Overflow saturates to Inf unless the mode rounds toward zero for this sign.
  function automatic logic ovf_to_inf(input logic [2:0] rnd, input logic s);
    case (rnd)
      RPINF:   return !s;
      RNINF:   return s;
      RZ:      return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Underflow flushes to zero unless the mode rounds away from zero for this sign.
  function automatic logic unf_to_zero(input logic [2:0] rnd, input logic s);
    case (rnd)
      RPINF:   return s;
      RNINF:   return !s;
      default: return 1'b1;
    endcase
  endfunction

  interp_t cls_a, cls_b, kind;
  logic    sgn;
  logic [W-1:0] nan_z;

  always_comb begin
    cls_a     = classify(a);
    cls_b     = classify(b);
    sgn       = a[W-1] ^ b[W-1];
    kind      = NORM;
    zero_f    = 1'b0;
    inf_f     = 1'b0;
    nan_f     = 1'b0;
    tiny_f    = 1'b0;
    huge_f    = 1'b0;
    inexact_f = 1'b0;
    invalid_f = 1'b0;

    if (cls_a == NAN || cls_b == NAN) begin
      kind  = NAN;
      nan_f = 1'b1;
    end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
      kind      = NAN;
      nan_f     = 1'b1;
      invalid_f = 1'b1;
    end else if (cls_a == INF || cls_b == INF) begin
      kind  = INF;
      inf_f = 1'b1;
    end else if (cls_a == ZERO || cls_b == ZERO) begin
      kind   = ZERO;
      zero_f = 1'b1;
    end else if (ovf) begin
      huge_f    = 1'b1;
      inexact_f = 1'b1;
      inf_f     = ovf_to_inf(round, sgn);
      kind      = inf_f ? INF : MAX_NORM;
    end else if (unf) begin
      tiny_f    = 1'b1;
      inexact_f = 1'b1;
      zero_f    = unf_to_zero(round, sgn);
      kind      = zero_f ? ZERO : MIN_NORM;
    end else begin
      inexact_f = inexact;
      zero_f    = ~|z_calc[W-2:0];
    end

`ifdef FP_MUL_EXC_NAN_PROP_EN
    // 0 x Inf has no NaN operand, so it always lands on the canonical value.
    if (invalid_f)          nan_z = NAN_C;
    else if (cls_a == NAN)  nan_z = a | QMASK;
    else                    nan_z = b | QMASK;
`else
    nan_z = NAN_C;
`endif

    case (kind)
      NAN:      z = nan_z;
      INF:      z = {sgn, INF_M};
      ZERO:     z = {sgn, {(W-1){1'b0}}};
      MAX_NORM: z = {sgn, MAXN_M};
      MIN_NORM: z = {sgn, MINN_M};
      default:  z = z_calc;
    endcase
  end

endmodule

// File: rtl/fp_mul_exc_stage.sv
// Registered FP multiplier exception stage with valid/ready handshake and
// sticky status flags.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake
//   a, b, z_calc, round     operands, datapath product, rounding mode
//   ovf, unf, inexact       datapath status
//   out_valid / out_ready   downstream handshake
//   z, zero_f .. invalid_f  registered result and per-result flags
//   flag_clr                synchronous clear of sticky flags (wins over accept)
//   sticky_f                {invalid, huge, tiny, inexact, nan} accumulated
// Build option: FP_MUL_EXC_NAN_PROP_EN (see fp_mul_exc_resolve).
module fp_mul_exc_stage
  import fp_mul_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     z_calc,
  input  logic [2:0]       round,
  input  logic             ovf,
  input  logic             unf,
  input  logic             inexact,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     z,
  output logic             zero_f,
  output logic             inf_f,
  output logic             nan_f,
  output logic             tiny_f,
  output logic             huge_f,
  output logic             inexact_f,
  output logic             invalid_f,
  input  logic             flag_clr,
  output logic [STK_W-1:0] sticky_f
);

  logic [W-1:0] res_z_p0;
  logic res_zero_p0, res_inf_p0, res_nan_p0, res_tiny_p0;
  logic res_huge_p0, res_inexact_p0, res_invalid_p0;
  logic accept_p0;
  logic [STK_W-1:0] res_stk_p0;

  fp_mul_exc_resolve #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_resolve (
    .a         (a),
    .b         (b),
    .z_calc    (z_calc),
    .round     (round),
    .ovf       (ovf),
    .unf       (unf),
    .inexact   (inexact),
    .z         (res_z_p0),
    .zero_f    (res_zero_p0),
    .inf_f     (res_inf_p0),
    .nan_f     (res_nan_p0),
    .tiny_f    (res_tiny_p0),
    .huge_f    (res_huge_p0),
    .inexact_f (res_inexact_p0),
    .invalid_f (res_invalid_p0)
  );

  logic         vld_p1;
  logic [W-1:0] z_p1;
  logic [6:0]   flg_p1;
  logic [STK_W-1:0] sticky_q;

  assign in_ready  = !vld_p1 || out_ready;
  assign accept_p0 = in_valid && in_ready;

  always_comb begin
    res_stk_p0              = '0;
    res_stk_p0[STK_NAN]     = res_nan_p0;
    res_stk_p0[STK_INEXACT] = res_inexact_p0;
    res_stk_p0[STK_TINY]    = res_tiny_p0;
    res_stk_p0[STK_HUGE]    = res_huge_p0;
    res_stk_p0[STK_INVALID] = res_invalid_p0;
  end

  // p0 -> p1: output register, held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      z_p1     <= '0;
      flg_p1   <= '0;
      sticky_q <= '0;
    end else begin
      if (accept_p0)      vld_p1 <= 1'b1;
      else if (out_ready) vld_p1 <= 1'b0;

      if (accept_p0) begin
        z_p1   <= res_z_p0;
        flg_p1 <= {res_zero_p0, res_inf_p0, res_nan_p0, res_tiny_p0,
                   res_huge_p0, res_inexact_p0, res_invalid_p0};
      end

      if (flag_clr)       sticky_q <= '0;
      else if (accept_p0) sticky_q <= sticky_q | res_stk_p0;
    end
  end

  assign out_valid = vld_p1;
  assign z         = z_p1;
  assign {zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f, invalid_f} = flg_p1;
  assign sticky_f  = sticky_q;

endmodule

// File: tb/tb_fp_mul_exc_stage.sv
module tb_fp_mul_exc_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0, z_calc = '0;
  logic [2:0]  round = 3'd4;
  logic        ovf = 1'b0, unf = 1'b0, inexact = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] z;
  logic        zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f, invalid_f;
  logic        flag_clr = 1'b0;
  logic [4:0]  sticky_f;

  fp_mul_exc_stage #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .z_calc(z_calc), .round(round), .ovf(ovf), .unf(unf),
    .inexact(inexact), .out_valid(out_valid), .out_ready(out_ready), .z(z),
    .zero_f(zero_f), .inf_f(inf_f), .nan_f(nan_f), .tiny_f(tiny_f),
    .huge_f(huge_f), .inexact_f(inexact_f), .invalid_f(invalid_f),
    .flag_clr(flag_clr), .sticky_f(sticky_f)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, n_push = 0, n_pop = 0;

  // fl = {zero, inf, nan, tiny, huge, inexact, invalid}
  typedef struct { logic [31:0] z; logic [6:0] fl; } exp_t;
  exp_t       q[$];
  exp_t       mon_e;
  logic [4:0] stk_m = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_nan(input logic [31:0] x);
    return ((x & 32'h7F800000) == 32'h7F800000) && ((x & 32'h007FFFFF) != 0);
  endfunction
  function automatic logic is_inf(input logic [31:0] x);
    return (x & 32'h7FFFFFFF) == 32'h7F800000;
  endfunction
  function automatic logic is_zero(input logic [31:0] x);
    return (x & 32'h7FFFFFFF) == 32'h0;
  endfunction

  // Reference behaviour for binary32, straight from the exception rules.
  function automatic exp_t model(input logic [31:0] ma, mb, mzc, input logic [2:0] rnd,
                                 input logic mo, mu, mi);
    exp_t r;
    logic s, big, flush;
    s    = ma[31] ^ mb[31];
    r.z  = mzc;
    r.fl = '0;
    if (is_nan(ma) || is_nan(mb)) begin
`ifdef FP_MUL_EXC_NAN_PROP_EN
      r.z = is_nan(ma) ? (ma | 32'h00400000) : (mb | 32'h00400000);
`else
      r.z = 32'h7F800001;
`endif
      r.fl = 7'b0010000;
    end else if ((is_inf(ma) && is_zero(mb)) || (is_zero(ma) && is_inf(mb))) begin
      r.z  = 32'h7F800001;
      r.fl = 7'b0010001;
    end else if (is_inf(ma) || is_inf(mb)) begin
      r.z  = s ? 32'hFF800000 : 32'h7F800000;
      r.fl = 7'b0100000;
    end else if (is_zero(ma) || is_zero(mb)) begin
      r.z  = s ? 32'h80000000 : 32'h00000000;
      r.fl = 7'b1000000;
    end else if (mo) begin
      big  = (rnd >= 3'd3) || (rnd == 3'd0 && !s) || (rnd == 3'd1 && s);
      r.z  = big ? (s ? 32'hFF800000 : 32'h7F800000) : (s ? 32'hFF7FFFFF : 32'h7F7FFFFF);
      r.fl = {1'b0, big, 5'b00110};
    end else if (mu) begin
      flush = (rnd >= 3'd2) || (rnd == 3'd0 && s) || (rnd == 3'd1 && !s);
      r.z   = flush ? (s ? 32'h80000000 : 32'h0) : (s ? 32'h80800000 : 32'h00800000);
      r.fl  = {flush, 6'b001010};
    end else begin
      r.fl = {is_zero(mzc), 4'b0000, mi, 1'b0};
    end
    return r;
  endfunction

  // Scoreboard / compare process: sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      stk_m = '0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_sticky", 64'(sticky_f), 64'd0);
      chk("rst_z", 64'(z), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
    end else begin
      chk("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
      chk("sticky", 64'(sticky_f), 64'(stk_m));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL spurious_out: out_valid=1 z=%0h with no pending result", z);
        end else begin
          chk("z", 64'(z), 64'(q[0].z));
          chk("flags", 64'({zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f, invalid_f}),
              64'(q[0].fl));
          if (out_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
      if (in_valid && in_ready) begin
        mon_e = model(a, b, z_calc, round, ovf, unf, inexact);
        q.push_back(mon_e);
        n_push++;
      end
      if (flag_clr) stk_m = '0;
      else if (in_valid && in_ready)
        stk_m = stk_m | {mon_e.fl[0], mon_e.fl[2], mon_e.fl[3], mon_e.fl[1], mon_e.fl[4]};
    end
  end

  task automatic drive(input logic [31:0] ta, tb, tzc, input logic [2:0] trnd,
                       input logic tovf, tunf, tinx);
    a = ta; b = tb; z_calc = tzc; round = trnd; ovf = tovf; unf = tunf; inexact = tinx;
  endtask

  // One accepted beat; called at posedge+1, returns at the next posedge+1.
  task automatic beat(input logic [31:0] ta, tb, tzc, input logic [2:0] trnd,
                      input logic tovf, tunf, tinx);
    drive(ta, tb, tzc, trnd, tovf, tunf, tinx);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  logic [31:0] ops [8] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                           32'h7FC00000, 32'hFF800005, 32'h3F800000, 32'hC0400000};
  exp_t pin;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // model pinned against hand-computed values
    pin = model(32'h00000000, 32'hFF800000, 32'h0, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("pin_invalid_z", 64'(pin.z), 64'h7F800001);
    chk("pin_invalid_fl", 64'(pin.fl), 64'b0010001);
    pin = model(32'hC0000000, 32'h40000000, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("pin_ovf_rpinf", 64'(pin.z), 64'hFF7FFFFF);
    pin = model(32'h3F800000, 32'h3F800000, 32'h0, 3'd2, 1'b0, 1'b1, 1'b0);
    chk("pin_unf_rz_fl", 64'(pin.fl), 64'b1001010);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle();

    beat(32'h7FC00000, 32'h3F800000, 32'h0, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("nan_out_valid", 64'(out_valid), 64'd1);
`ifdef FP_MUL_EXC_NAN_PROP_EN
    chk("nan_z", 64'(z), 64'h7FC00000);
`else
    chk("nan_z", 64'(z), 64'h7F800001);
`endif
    chk("nan_f", 64'(nan_f), 64'd1);
    chk("nan_invalid_f", 64'(invalid_f), 64'd0);

    beat(32'h00000000, 32'hFF800000, 32'h0, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("inv_z", 64'(z), 64'h7F800001);
    chk("inv_flags", 64'({nan_f, invalid_f}), 64'b11);
    chk("inv_sticky4", 64'(sticky_f[4]), 64'd1);

    beat(32'hC0000000, 32'h40000000, 32'h0, 3'd0, 1'b1, 1'b0, 1'b0);
    chk("ovf_rpinf_z", 64'(z), 64'hFF7FFFFF);
    chk("ovf_rpinf_fl", 64'({huge_f, inf_f, inexact_f}), 64'b101);
    beat(32'hC0000000, 32'h40000000, 32'h0, 3'd1, 1'b1, 1'b0, 1'b0);
    chk("ovf_rninf_z", 64'(z), 64'hFF800000);
    chk("ovf_rninf_inf", 64'(inf_f), 64'd1);

    beat(32'h3F800000, 32'h3F800000, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("unf_rpinf_z", 64'(z), 64'h00800000);
    chk("unf_rpinf_fl", 64'({tiny_f, zero_f}), 64'b10);
    beat(32'h3F800000, 32'h3F800000, 32'h0, 3'd2, 1'b0, 1'b1, 1'b0);
    chk("unf_rz_z", 64'(z), 64'h00000000);
    chk("unf_rz_zero", 64'(zero_f), 64'd1);

    beat(32'h3FC00000, 32'h40000000, 32'h40400000, 3'd4, 1'b0, 1'b0, 1'b1);
    chk("norm_z", 64'(z), 64'h40400000);
    chk("norm_fl", 64'({zero_f, inexact_f}), 64'b01);

    beat(32'h7F800000, 32'hBF800000, 32'h0, 3'd4, 1'b1, 1'b0, 1'b1);
    chk("inf_z", 64'(z), 64'hFF800000);
    chk("inf_ignores_ovf", 64'({inf_f, huge_f, inexact_f}), 64'b100);

    beat(32'h00000000, 32'hBF800000, 32'h0, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("zero_z", 64'(z), 64'h80000000);
    chk("zero_f", 64'(zero_f), 64'd1);

    // stall: result held, nothing overwritten
    idle();
    out_ready = 1'b0;
    beat(32'h3F800000, 32'h40000000, 32'h40000000, 3'd4, 1'b0, 1'b0, 1'b0);
    drive(32'h40000000, 32'h40000000, 32'h40800000, 3'd4, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("stall_z", 64'(z), 64'h40000000);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    idle();
    chk("unstall_z", 64'(z), 64'h40800000);

    // back-to-back streaming
    for (int i = 0; i < 24; i++) begin
      drive(ops[i % 8], ops[(i * 3 + 1) % 8], 32'(i) << 20, 3'(i % 8),
            1'(i % 3 == 0), 1'(i % 3 == 1), 1'(i % 2));
      idle();
    end
    in_valid = 1'b0;
    idle();
    idle();
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_queue", 64'(q.size()), 64'd0);
    chk("push_eq_pop", 64'(n_push), 64'(n_pop));

    // clear wins over a coincident invalid result
    flag_clr = 1'b1;
    beat(32'h00000000, 32'h7F800000, 32'h0, 3'd4, 1'b0, 1'b0, 1'b0);
    flag_clr = 1'b0;
    chk("clr_wins", 64'(sticky_f), 64'd0);
    beat(32'h00000000, 32'h7F800000, 32'h0, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("sticky_after_inv", 64'(sticky_f), 64'b10001);

    // reset mid-transfer drops the held result
    idle();
    out_ready = 1'b0;
    beat(32'h3F800000, 32'h40000000, 32'h40000000, 3'd4, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_sticky", 64'(sticky_f), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle();
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    beat(32'h40000000, 32'hC0000000, 32'hC0800000, 3'd4, 1'b0, 1'b0, 1'b0);
    chk("post_rst_z", 64'(z), 64'hC0800000);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_exc_stage.md
Name: fp_mul_exc_stage

Overview:
- Parametrised, registered successor of the combinational FP-multiply exception stage.
- Sits after the mantissa/exponent datapath of the FP multiplier.
- Classifies operands and resolves NaN, Inf, zero, overflow and underflow into a final result plus per-result status flags.
- Adds a valid/ready handshake, one output register stage, IEEE invalid detection (0 × Inf) and sticky accumulated flags.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: mantissa (fraction) field width.
- W, 1+EXP_W+MAN_W: word width. Derived; not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream result valid.
- in_ready  out  1  stage can accept.
- a, b  in  W each  original operands.
- z_calc  in  W  datapath-rounded product.
- round  in  3  rounding mode (rnd_t).
- ovf, unf, inexact  in  1 each  datapath status.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- z  out  W  final result.
- zero_f, inf_f, nan_f, tiny_f, huge_f, inexact_f, invalid_f  out  1 each  per-result flags.
- flag_clr  in  1  synchronous clear of sticky flags.
- sticky_f  out  5  {invalid, huge, tiny, inexact, nan} accumulated.

Behaviour:
- Reset (async, rst_n low): out_valid=0, z=0, all per-result flags=0, sticky_f=0. in_ready is derived combinationally (see below), so it reads 1 during reset. A transfer in flight is dropped.
- Handshake:
  - in_ready = !out_valid || out_ready.
  - Input accepted on a clk edge when in_valid && in_ready. Result registered with latency 1.
  - out_valid held, and z/flags held stable, until out_valid && out_ready.
  - Simultaneous pop and push gives back-to-back throughput of 1 per cycle with no bubble.
- Classification per operand (exp=EXP field, man=MAN field):
  - ZERO: exp=0 and man=0.
  - INF: exp all ones and man=0.
  - NAN: exp all ones and man≠0.
  - NORM: otherwise. Subnormals are treated as NORM.
- sgn = a[W-1]^b[W-1].
- Priority, first match wins:
  1. Either operand NAN → canonical NaN {0, ones, 0..01}; nan_f=1.
  2. One operand INF and the other ZERO → canonical NaN; nan_f=1, invalid_f=1.
  3. Either operand INF → {sgn, ones, 0}; inf_f=1.
  4. Either operand ZERO → {sgn, 0}; zero_f=1.
  5. ovf → huge_f=1, inexact_f=1.
     - Result is Inf (inf_f=1) if round=RNE, or RNA, or RPINF with sgn=0, or RNINF with sgn=1.
     - Otherwise result is MAX_NORM {sgn, ones-1, all ones}.
  6. unf → tiny_f=1, inexact_f=1.
     - Result is ±0 (zero_f=1) if round=RNE, RNA, RZ, RPINF with sgn=1, or RNINF with sgn=0.
     - Otherwise result is MIN_NORM {sgn, 0..01, 0}.
  7. Otherwise z=z_calc, inexact_f=inexact; zero_f set if z_calc magnitude is 0.
- Per-result flags from cases 1–4 ignore ovf, unf and inexact.
- Rounding-mode encoding (rnd_t): 000 RPINF, 001 RNINF, 010 RZ, 011 RNA, 100 RNE. Codes 101–111 behave as RNE.
- Sticky flags:
  - Each bit is set by OR of the corresponding flag on every accepted input.
  - flag_clr clears all bits; if clear and accept happen in the same cycle, clear wins and the accepted flags are discarded.
  - Sticky bits do not clear on pop.

Optional Feature:
- Macro: FP_MUL_EXC_NAN_PROP_EN.
- Defined: a NaN input propagates its own payload, quieted (man MSB forced 1) and with its sign kept; a takes priority over b. Invalid 0×Inf still gives the canonical NaN.
- Undefined: every NaN result is canonical, exactly as in case 1.

Decomposition:
- Package fp_mul_pkg holds:
  - rnd_t enum.
  - interp_t enum {ZERO, INF, NAN, NORM, MIN_NORM, MAX_NORM}.
  - Parametrised constant functions for the special-value encodings, taking EXP_W and MAN_W.
  - Sticky-bit index constants.
- One natural sub-module, fp_mul_exc_resolve: purely combinational classification and priority resolution. The top level holds the register stage, handshake and sticky logic.

Test Plan (EXP_W=8, MAN_W=23):
- a=0x7FC00000, b=0x3F800000, out_ready=1 → next cycle z=0x7F800001, nan_f=1, out_valid=1; 0x7FC00000 with NAN_PROP_EN.
- a=0x00000000, b=0xFF800000 → z=0x7F800001, nan_f=1, invalid_f=1, sticky_f[4]=1.
- a=0xC0000000, b=0x40000000, ovf=1, round=RPINF → z=0xFF7FFFFF, huge_f=1, inf_f=0; round=RNINF → z=0xFF800000, inf_f=1.
- unf=1, sgn=0, round=RPINF → z=0x00800000, tiny_f=1; round=RZ → z=0x00000000, zero_f=1.
- out_ready=0 for 3 cycles with in_valid=1 → z held, in_ready=0, no overwrite. Then out_ready=1 with continuous in_valid → one result per cycle, none lost or duplicated.
- rst_n pulsed low mid-transfer → out_valid=0 and sticky_f=0 immediately. flag_clr coincident with an invalid input → sticky_f stays 0.
